// File: rtl/rx_sampler.sv
// Oversampling UART receive front end: synchronizes rx, finds bit centres and
// hands each data bit to a downstream SIPO via a one-clock shift strobe.
module rx_sampler #(
    parameter int WIDTH = 8,
    parameter int OVS   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic rx,
    input  logic en,
    output logic sh_bit,
    output logic sh_en,
    output logic rx_done,
    output logic frame_err,
    output logic busy
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   tick_cnt_reg, tick_cnt_next;
    logic [BW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic            sh_bit_reg, sh_bit_next;
    logic            sh_en_reg, sh_en_next;
    logic            rx_done_reg, rx_done_next;
    logic            frame_err_reg, frame_err_next;
    logic            rx_meta_reg, rxs_reg;

    // Both stages reset to the idle line level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rxs_reg     <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            tick_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            sh_bit_reg    <= 1'b0;
            sh_en_reg     <= 1'b0;
            rx_done_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tick_cnt_reg  <= tick_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            sh_bit_reg    <= sh_bit_next;
            sh_en_reg     <= sh_en_next;
            rx_done_reg   <= rx_done_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tick_cnt_next  = tick_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        sh_bit_next    = sh_bit_reg;
        sh_en_next     = 1'b0;
        rx_done_next   = 1'b0;
        frame_err_next = 1'b0;

        if (!en) begin
            state_next    = IDLE;
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
        end else if (baud_tick) begin
            tick_cnt_next = (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    bit_cnt_next = '0;
                    if (!rxs_reg) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (tick_cnt_reg == TICK_HALF) begin
                        state_next = rxs_reg ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        sh_bit_next  = rxs_reg;
                        sh_en_next   = 1'b1;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        if (rxs_reg) begin
                            rx_done_next = 1'b1;
                            state_next   = IDLE;
                        end else begin
                            frame_err_next = 1'b1;
                            state_next     = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs_reg) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
            // Each state measures its own time from zero.
            if (state_next != state_reg) begin
                tick_cnt_next = '0;
            end
        end
    end

    assign sh_bit    = sh_bit_reg;
    assign sh_en     = sh_en_reg;
    assign rx_done   = rx_done_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_rx_sampler.sv
// Directed bench for rx_sampler: drives whole serial frames aligned to baud ticks
// and checks strobe counts, captured bit values and completion pulses.
module tb_rx_sampler;

    localparam int WIDTH = 8;
    localparam int OVS   = 16;

    logic clk = 1'b0;
    logic rst;
    logic baud_tick;
    logic rx;
    logic en;
    logic sh_bit;
    logic sh_en;
    logic rx_done;
    logic frame_err;
    logic busy;

    int n_pass   = 0;
    int n_total  = 0;
    int sh_cnt   = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int dbl_cnt  = 0;
    int busy_cnt = 0;
    int div_cnt  = 0;
    logic prev_sh = 1'b0;
    logic cap [0:255];

    rx_sampler #(.WIDTH(WIDTH), .OVS(OVS)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx        (rx),
        .en        (en),
        .sh_bit    (sh_bit),
        .sh_en     (sh_en),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One baud tick every second clock, changed on the falling edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            div_cnt   = div_cnt + 1;
            baud_tick = (div_cnt % 2 == 0);
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sh_en === 1'b1) begin
                if (sh_cnt < 256) cap[sh_cnt] = sh_bit;
                sh_cnt = sh_cnt + 1;
            end
            if (rx_done === 1'b1) done_cnt = done_cnt + 1;
            if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
            if (rx_done === 1'b1 && frame_err === 1'b1) both_cnt = both_cnt + 1;
            if (sh_en === 1'b1 && prev_sh === 1'b1) dbl_cnt = dbl_cnt + 1;
            if (busy === 1'b1) busy_cnt = busy_cnt + 1;
            prev_sh = sh_en;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        seen = 0;
        while (seen < n) begin
            @(posedge clk);
            #1;
            if (baud_tick) seen++;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(OVS);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < WIDTH; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    function automatic logic [7:0] get_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = cap[base + i];
        return b;
    endfunction

    int s0, d0, f0, b0;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        rx  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_sh_en", sh_en, 0);
        check("reset_rx_done", rx_done, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_sh_bit", sh_bit, 0);
        rst = 1'b0;
        wait_ticks(4);

        // Clean 0xA5 frame
        s0 = sh_cnt; d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        $display("frame 0xA5: strobes=%0d byte=0x%0h done=%0d", sh_cnt - s0, get_byte(s0), done_cnt - d0);
        check("a5_strobes", sh_cnt - s0, 8);
        check("a5_bits", get_byte(s0), 8'hA5);
        check("a5_done", done_cnt - d0, 1);
        check("a5_ferr", ferr_cnt - f0, 0);
        check("a5_busy", busy, 0);
        check("a5_sh_bit_hold", sh_bit, 1);

        // Short low glitch is rejected at mid start bit
        s0 = sh_cnt; d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        wait_ticks(4);
        check("glitch_busy_mid", busy, 1);
        rx = 1'b1;
        wait_ticks(8);
        check("glitch_idle", busy, 0);
        wait_ticks(20);
        $display("glitch: strobes=%0d done=%0d ferr=%0d", sh_cnt - s0, done_cnt - d0, ferr_cnt - f0);
        check("glitch_strobes", sh_cnt - s0, 0);
        check("glitch_pulses", (done_cnt - d0) + (ferr_cnt - f0), 0);

        // 0x3C with bad stop bit, line held low for three more bit periods
        s0 = sh_cnt; d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        wait_ticks(3 * OVS);
        $display("frame 0x3C/bad stop: strobes=%0d byte=0x%0h ferr=%0d", sh_cnt - s0, get_byte(s0), ferr_cnt - f0);
        check("ferr_strobes", sh_cnt - s0, 8);
        check("ferr_bits", get_byte(s0), 8'h3C);
        check("ferr_pulse", ferr_cnt - f0, 1);
        check("ferr_no_done", done_cnt - d0, 0);
        check("ferr_busy_held", busy, 1);
        rx = 1'b1;
        wait_ticks(4);
        check("ferr_release", busy, 0);
        wait_ticks(40);
        check("ferr_no_restart", sh_cnt - s0, 8);
        check("ferr_idle", busy, 0);

        // Reset after the third strobe of a frame
        s0 = sh_cnt; d0 = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("rst_pre_strobes", sh_cnt - s0, 3);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sh_en", sh_en, 0);
        check("rst_done", rx_done, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_sh_bit", sh_bit, 0);
        rst = 1'b0;
        wait_ticks(20);
        check("rst_quiet", sh_cnt - s0, 3);
        s0 = sh_cnt; d0 = done_cnt;
        send_frame(8'h55, 1'b1);
        $display("frame 0x55 after reset: strobes=%0d byte=0x%0h done=%0d", sh_cnt - s0, get_byte(s0), done_cnt - d0);
        check("post_rst_strobes", sh_cnt - s0, 8);
        check("post_rst_bits", get_byte(s0), 8'h55);
        check("post_rst_done", done_cnt - d0, 1);

        // Enable dropped mid-DATA of 0x96, then a whole frame with en=0
        s0 = sh_cnt; d0 = done_cnt; f0 = ferr_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("en_off_idle", busy, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        $display("frame 0x96/en dropped: strobes=%0d done=%0d", sh_cnt - s0, done_cnt - d0);
        check("en_off_strobes", sh_cnt - s0, 3);
        check("en_off_done", done_cnt - d0, 0);
        s0 = sh_cnt; d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        send_frame(8'hC3, 1'b1);
        $display("frame 0xC3/en low: strobes=%0d done=%0d busy_cycles=%0d", sh_cnt - s0, done_cnt - d0, busy_cnt - b0);
        check("en_low_strobes", sh_cnt - s0, 0);
        check("en_low_pulses", (done_cnt - d0) + (ferr_cnt - f0), 0);
        check("en_low_busy", busy_cnt - b0, 0);
        en = 1'b1;
        wait_ticks(4);

        // Back-to-back 0x00 then 0xFF with no idle gap
        s0 = sh_cnt; d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        $display("frames 0x00,0xFF: strobes=%0d bytes=0x%0h,0x%0h done=%0d ferr=%0d",
                 sh_cnt - s0, get_byte(s0), get_byte(s0 + 8), done_cnt - d0, ferr_cnt - f0);
        check("b2b_strobes", sh_cnt - s0, 16);
        check("b2b_first", get_byte(s0), 8'h00);
        check("b2b_second", get_byte(s0 + 8), 8'hFF);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_ferr", ferr_cnt - f0, 0);
        check("b2b_busy", busy, 0);

        check("never_done_and_ferr", both_cnt, 0);
        check("sh_en_single_clk", dbl_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
